// File: rtl/pdp8_pkg.sv
// Shared definitions for the PDP-8 Operate Group 1 datapath.
package pdp8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_CMP  = 3'd2,
    ST_INC  = 3'd3,
    ST_ROT  = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  // IR bit positions within the Group 1 microinstruction
  localparam int unsigned IR_CLA = 7;
  localparam int unsigned IR_CLL = 6;
  localparam int unsigned IR_CMA = 5;
  localparam int unsigned IR_CML = 4;
  localparam int unsigned IR_RAR = 3;
  localparam int unsigned IR_RAL = 2;
  localparam int unsigned IR_BSW = 1;
  localparam int unsigned IR_IAC = 0;

  // Rotater op codes {RAR,RAL,TWICE/BSW}
  localparam logic [2:0] ROP_NOP = 3'b000;
  localparam logic [2:0] ROP_RAR = 3'b100;
  localparam logic [2:0] ROP_RAL = 3'b010;
  localparam logic [2:0] ROP_RTR = 3'b101;
  localparam logic [2:0] ROP_RTL = 3'b011;
  localparam logic [2:0] ROP_BSW = 3'b001;

  // First enabled event strictly after 'from' (events ordered CLR,CMP,INC,ROT);
  // FIN when none remain. With skip=0 every event counts as enabled.
  function automatic state_t next_event(input state_t from, input logic [7:0] irq,
                                        input logic skip);
    logic [3:0]  en;
    logic        found;
    int unsigned first;
    state_t      nxt;
    en[0] = ~skip | irq[IR_CLA] | irq[IR_CLL];
    en[1] = ~skip | irq[IR_CMA] | irq[IR_CML];
    en[2] = ~skip | irq[IR_IAC];
    en[3] = ~skip | irq[IR_RAR] | irq[IR_RAL] | irq[IR_BSW];
    first = int'(from);
    found = 1'b0;
    nxt   = ST_FIN;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && i >= first && en[i[1:0]]) begin
        nxt   = state_t'(3'(i + 1));
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/opr1_sequencer.sv
// PDP-8 Operate Group 1 sequencer: owns AC/Link and steps CLR, CMP, INC, ROT.
module opr1_sequencer
  import pdp8_pkg::*;
#(
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [11:0] IR,
  input  logic        AC_LD,
  input  logic [11:0] AC_DIN,
  input  logic        L_DIN,
  input  logic [11:0] ROT_AO,
  input  logic        ROT_LO,
  output logic [2:0]  ROT_OP,
  output logic [11:0] ROT_AI,
  output logic        ROT_LI,
  output logic        ROT_OE,
  output logic [11:0] AC,
  output logic        L,
  output logic        BUSY,
  output logic        DONE
);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_irq, w_irq_nxt;
  logic [11:0] r_ac, w_ac_nxt;
  logic        r_l, w_l_nxt;
  logic [12:0] w_inc;
  logic        w_unused_ir_hi;

  // Opcode field is guaranteed by the controller and intentionally ignored
  assign w_unused_ir_hi = ^IR[11:8];

  // State and datapath registers
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_irq   <= '0;
      r_ac    <= '0;
      r_l     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= w_irq_nxt;
      r_ac    <= w_ac_nxt;
      r_l     <= w_l_nxt;
    end
  end

  // Next-state and per-event AC/Link update
  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_ac_nxt    = r_ac;
    w_l_nxt     = r_l;
    w_inc       = {1'b0, r_ac} + 13'd1;
    unique case (r_state)
      ST_IDLE: begin
        // An external load wins over a coincident START, which is dropped
        if (AC_LD) begin
          w_ac_nxt = AC_DIN;
          w_l_nxt  = L_DIN;
        end else if (START) begin
          w_irq_nxt   = IR[7:0];
          w_state_nxt = next_event(ST_IDLE, IR[7:0], SKIP_EMPTY);
        end
      end
      ST_CLR: begin
        if (r_irq[IR_CLA]) w_ac_nxt = '0;
        if (r_irq[IR_CLL]) w_l_nxt = 1'b0;
        w_state_nxt = next_event(ST_CLR, r_irq, SKIP_EMPTY);
      end
      ST_CMP: begin
        if (r_irq[IR_CMA]) w_ac_nxt = ~r_ac;
        if (r_irq[IR_CML]) w_l_nxt = ~r_l;
        w_state_nxt = next_event(ST_CMP, r_irq, SKIP_EMPTY);
      end
      ST_INC: begin
        if (r_irq[IR_IAC]) begin
          w_ac_nxt = w_inc[11:0];
          w_l_nxt  = r_l ^ w_inc[12];
        end
        w_state_nxt = next_event(ST_INC, r_irq, SKIP_EMPTY);
      end
      ST_ROT: begin
        if (|r_irq[IR_RAR:IR_BSW]) begin
          w_ac_nxt = ROT_AO;
          w_l_nxt  = ROT_LO;
        end
        w_state_nxt = ST_FIN;
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ROT_OP = (r_state == ST_ROT) ? r_irq[IR_RAR:IR_BSW] : ROP_NOP;
  assign ROT_OE = (r_state == ST_ROT);
  assign ROT_AI = r_ac;
  assign ROT_LI = r_l;
  assign AC     = r_ac;
  assign L      = r_l;
  assign BUSY   = (r_state != ST_IDLE);
  assign DONE   = (r_state == ST_FIN);

endmodule

// File: tb/tb_opr1_sequencer.sv
// Directed bench for opr1_sequencer with a behavioural rotater alongside it.
module tb_opr1_sequencer;

  logic        SYSCLK = 1'b0;
  logic        RESET  = 1'b1;
  logic        START  = 1'b0;
  logic [11:0] IR     = '0;
  logic        AC_LD  = 1'b0;
  logic [11:0] AC_DIN = '0;
  logic        L_DIN  = 1'b0;
  logic [11:0] ROT_AO;
  logic        ROT_LO;
  logic [2:0]  ROT_OP;
  logic [11:0] ROT_AI;
  logic        ROT_LI;
  logic        ROT_OE;
  logic [11:0] AC;
  logic        L;
  logic        BUSY;
  logic        DONE;

  opr1_sequencer #(.SKIP_EMPTY(1'b1)) u_dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .START(START), .IR(IR),
    .AC_LD(AC_LD), .AC_DIN(AC_DIN), .L_DIN(L_DIN),
    .ROT_AO(ROT_AO), .ROT_LO(ROT_LO), .ROT_OP(ROT_OP), .ROT_AI(ROT_AI),
    .ROT_LI(ROT_LI), .ROT_OE(ROT_OE), .AC(AC), .L(L), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Rotater model: OP = {RAR,RAL,TWICE/BSW} acting on the 13-bit {L,AC}
  always_comb begin
    ROT_AO = ROT_AI;
    ROT_LO = ROT_LI;
    case (ROT_OP)
      3'b100: begin ROT_LO = ROT_AI[0];  ROT_AO = {ROT_LI, ROT_AI[11:1]}; end
      3'b101: begin ROT_LO = ROT_AI[1];  ROT_AO = {ROT_AI[0], ROT_LI, ROT_AI[11:2]}; end
      3'b010: begin ROT_LO = ROT_AI[11]; ROT_AO = {ROT_AI[10:0], ROT_LI}; end
      3'b011: begin ROT_LO = ROT_AI[10]; ROT_AO = {ROT_AI[9:0], ROT_LI, ROT_AI[11]}; end
      3'b001: ROT_AO = {ROT_AI[5:0], ROT_AI[11:6]};
      default: ;
    endcase
  end

  typedef struct {
    logic [11:0] ac;
    logic        l;
    int unsigned cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int unsigned rot_cnt  = 0;
  logic [2:0]  rot_op_seen = '0;

  always @(posedge SYSCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Output side of the scoreboard: every DONE pops one expected result
  always @(negedge SYSCLK) begin
    if (ROT_OE === 1'b1) begin
      rot_cnt++;
      rot_op_seen = ROT_OP;
    end
    if (DONE === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'(DONE), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_ac"},   32'(AC),   32'(e.ac));
        check({e.tag, "_l"},    32'(L),    32'(e.l));
        check({e.tag, "_cyc"},  cyc,       e.cyc);
        check({e.tag, "_busy"}, 32'(BUSY), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic load(input logic [11:0] ac, input logic l);
    AC_LD = 1'b1; AC_DIN = ac; L_DIN = l;
    tick();
    AC_LD = 1'b0;
  endtask

  // Drive a one-cycle START; n = number of enabled events
  task automatic start(input logic [11:0] ir, input int unsigned n, input bit push,
                       input logic [11:0] ac, input logic l, input string tag);
    exp_t e;
    START = 1'b1; IR = ir;
    if (push) begin
      e.ac = ac; e.l = l; e.cyc = cyc + 1 + n; e.tag = tag;
      sb.push_back(e);
    end
    tick();
    START = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned k;
    k = 0;
    while (BUSY !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 32'(BUSY), 32'd0);
  endtask

  int unsigned d0, r0;

  initial begin
    // 1. reset
    tick(); tick();
    RESET = 1'b0;
    check("rst_ac",   32'(AC),     32'd0);
    check("rst_l",    32'(L),      32'd0);
    check("rst_busy", 32'(BUSY),   32'd0);
    check("rst_done", 32'(DONE),   32'd0);
    check("rst_oe",   32'(ROT_OE), 32'd0);
    check("rst_op",   32'(ROT_OP), 32'd0);

    // 2. IAC carry out of AC[11]
    load(12'o7777, 1'b0);
    start(12'o7001, 1, 1'b1, 12'o0000, 1'b1, "iac");
    wait_idle("iac");

    // 3. CLL RAR, single rotate cycle with OP=100
    load(12'o0001, 1'b1);
    r0 = rot_cnt;
    start(12'o7110, 2, 1'b1, 12'o0000, 1'b1, "cll_rar");
    wait_idle("cll_rar");
    check("rar_oe_cycles", rot_cnt - r0, 32'd1);
    check("rar_op", 32'(rot_op_seen), 32'b100);

    // 4. CLA CMA IAC
    load(12'o1234, 1'b0);
    start(12'o7241, 3, 1'b1, 12'o0000, 1'b1, "cla_cma_iac");
    wait_idle("cla_cma_iac");

    // 5. byte swap, rotate-twice-left, RAR+RAL pass-through, empty instruction
    load(12'o0077, 1'b1);
    start(12'o7002, 1, 1'b1, 12'o7700, 1'b1, "bsw");
    wait_idle("bsw");
    load(12'o4000, 1'b0);
    start(12'o7006, 1, 1'b1, 12'o0001, 1'b0, "rtl");
    wait_idle("rtl");
    start(12'o7014, 1, 1'b1, 12'o0001, 1'b0, "rar_ral");
    wait_idle("rar_ral");
    start(12'o7000, 0, 1'b1, 12'o0001, 1'b0, "nop");
    wait_idle("nop");

    // AC_LD with START in the same idle cycle: load taken, START dropped
    AC_LD = 1'b1; AC_DIN = 12'o0055; L_DIN = 1'b1; START = 1'b1; IR = 12'o7001;
    tick();
    AC_LD = 1'b0; START = 1'b0;
    check("ld_start_busy", 32'(BUSY), 32'd0);
    check("ld_start_ac",   32'(AC),   32'o0055);
    check("ld_start_l",    32'(L),    32'd1);

    // 6a. reset during CMP aborts with no DONE
    load(12'o1234, 1'b1);
    d0 = done_cnt;
    start(12'o7241, 3, 1'b0, '0, 1'b0, "abort");
    tick();
    check("abort_busy_cmp", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("abort_ac",   32'(AC),   32'd0);
    check("abort_l",    32'(L),    32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    repeat (6) tick();
    check("abort_no_done", done_cnt - d0, 32'd0);

    // 6b. START and AC_LD while busy are ignored
    load(12'o1234, 1'b0);
    d0 = done_cnt;
    start(12'o7241, 3, 1'b1, 12'o0000, 1'b1, "busy_ign");
    START = 1'b1; IR = 12'o7001; AC_LD = 1'b1; AC_DIN = 12'o5555; L_DIN = 1'b0;
    tick(); tick();
    START = 1'b0; AC_LD = 1'b0;
    wait_idle("busy_ign");
    repeat (4) tick();
    check("busy_one_done", done_cnt - d0, 32'd1);
    check("busy_still_idle", 32'(BUSY), 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
